// File: rtl/sweep_pkg.sv
// Shared definitions for the triangle-sweep controller and its helpers.
package sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP   = 3'd1,
        ST_TOP  = 3'd2,
        ST_DOWN = 3'd3,
        ST_BOT  = 3'd4
    } state_e;

    localparam logic UP_DIR = 1'b0;
    localparam logic DN_DIR = 1'b1;

    localparam logic [4:0] CNT_MIN = 5'd0;
    localparam logic [4:0] CNT_MAX = 5'd31;

endpackage

// File: rtl/sweep_ctrl_dwell_timer.sv
// Loadable down-counter with a zero flag, shared by the top and bottom holds.
module dwell_timer #(
    parameter int DW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [DW-1:0] load_val_i,
    output logic          zero_o
);

    logic [DW-1:0] count_q;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - DW'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle-sweep controller driving the enable/direction of a 5-bit up/down counter.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [DW-1:0] cycles,
    input  logic [DW-1:0] dwell,
    input  logic          up_full,
    input  logic          down_empty,
    output logic          cnt_en,
    output logic          cnt_type,
    output logic          busy,
    output logic          done,
    output logic [2:0]    phase
);

    state_e        state_q, state_d;
    logic [DW-1:0] cycles_q;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] period_q;
    logic [DW-1:0] period_next;
    logic          busy_q;
    logic          done_q, done_d;
    logic          latch_d;
    logic          period_inc_d;
    logic          timer_load_d;
    logic          timer_dec_d;
    logic          timer_zero;

    assign period_next = period_q + DW'(1);

    dwell_timer #(.DW(DW)) u_dwell_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (timer_load_d),
        .dec_i      (timer_dec_d),
        .load_val_i (dwell_q - DW'(1)),
        .zero_o     (timer_zero)
    );

    // Next-state decode; stop overrides everything once the sweep is running.
    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        latch_d      = 1'b0;
        period_inc_d = 1'b0;
        timer_load_d = 1'b0;
        timer_dec_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_UP;
                    latch_d = 1'b1;
                end
            end
            ST_UP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (up_full) begin
                    if (dwell_q == '0) begin
                        state_d = ST_DOWN;
                    end else begin
                        state_d      = ST_TOP;
                        timer_load_d = 1'b1;
                    end
                end
            end
            ST_TOP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (timer_zero) begin
                    state_d = ST_DOWN;
                end else begin
                    timer_dec_d = 1'b1;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (down_empty) begin
                    period_inc_d = 1'b1;
                    if ((cycles_q != '0) && (period_next == cycles_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (dwell_q == '0) begin
                        state_d = ST_UP;
                    end else begin
                        state_d      = ST_BOT;
                        timer_load_d = 1'b1;
                    end
                end
            end
            ST_BOT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (timer_zero) begin
                    state_d = ST_UP;
                end else begin
                    timer_dec_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched configuration, period count and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cycles_q <= '0;
            dwell_q  <= '0;
            period_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
            if (latch_d) begin
                cycles_q <= cycles;
                dwell_q  <= dwell;
                period_q <= '0;
            end else if (period_inc_d) begin
                period_q <= period_next;
            end
        end
    end

    // Enable is gated by the end flags and by stop in the same cycle so the counter never wraps.
    always_comb begin
        cnt_en   = 1'b0;
        cnt_type = UP_DIR;
        case (state_q)
            ST_UP:   cnt_en = !up_full && !stop;
            ST_DOWN: cnt_en = !down_empty && !stop;
            default: cnt_en = 1'b0;
        endcase
        if ((state_q == ST_TOP) || (state_q == ST_DOWN)) begin
            cnt_type = DN_DIR;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign phase = state_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl with a behavioural 5-bit up/down counter attached.
module tb_sweep_ctrl;
    import sweep_pkg::*;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [3:0] cycles = 4'd0;
    logic [3:0] dwell  = 4'd0;
    logic       upFull, downEmpty;
    logic       cntEn, cntType, busy, done;
    logic [2:0] phase;

    logic [4:0] count   = 5'd0;
    logic       loadReq = 1'b0;
    logic [4:0] loadVal = 5'd0;

    int total    = 0;
    int bad      = 0;
    int wrapErrs = 0;
    int typeErrs = 0;

    sweep_ctrl #(.DW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cycles     (cycles),
        .dwell      (dwell),
        .up_full    (upFull),
        .down_empty (downEmpty),
        .cnt_en     (cntEn),
        .cnt_type   (cntType),
        .busy       (busy),
        .done       (done),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    assign upFull    = (count == CNT_MAX);
    assign downEmpty = (count == CNT_MIN);

    // Counter model: +1 or +31 (i.e. -1) when enabled, with a bench-side preload.
    always @(posedge clk) begin
        if (loadReq) count <= loadVal;
        else if (cntEn) count <= cntType ? count + 5'd31 : count + 5'd1;
    end

    // Invariant monitor: no wrap at the extremes and direction tracks the phase.
    always @(negedge clk) begin
        if (cntEn && !cntType && count == CNT_MAX) wrapErrs++;
        if (cntEn && cntType && count == CNT_MIN) wrapErrs++;
        if (cntType != ((phase == ST_TOP) || (phase == ST_DOWN))) typeErrs++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic [3:0] cy, input logic [3:0] dw);
        start  = st;
        stop   = sp;
        cycles = cy;
        dwell  = dw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadCount(input logic [4:0] v);
        loadReq = 1'b1;
        loadVal = v;
        tick();
        loadReq = 1'b0;
    endtask

    // Runs one started sweep to its done pulse; the first edge is the start edge.
    task automatic runSweep(input string name, input int budget,
                            input int expDone, input int expUp, input int expDown,
                            input int expTop, input int expBot, input int expBusy);
        int doneAt = 0, upSteps = 0, downSteps = 0, topCyc = 0, botCyc = 0, busyCyc = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (k == 1) begin
                applyStimulus(1'b0, 1'b0, 4'd7, 4'd7);
                checkOutput({name, ".busy1"}, busy, 1);
                checkOutput({name, ".en1"}, cntEn, 1);
                checkOutput({name, ".phase1"}, phase, 1);
            end
            if (done) begin
                doneAt = k;
                checkOutput({name, ".phaseAtDone"}, phase, 0);
                checkOutput({name, ".busyAtDone"}, busy, 0);
                break;
            end
            if (cntEn && !cntType) upSteps++;
            if (cntEn && cntType) downSteps++;
            if (phase == ST_TOP) topCyc++;
            if (phase == ST_BOT) botCyc++;
            if (busy) busyCyc++;
        end
        checkOutput({name, ".doneAt"}, doneAt, expDone);
        checkOutput({name, ".upSteps"}, upSteps, expUp);
        checkOutput({name, ".downSteps"}, downSteps, expDown);
        checkOutput({name, ".topCycles"}, topCyc, expTop);
        checkOutput({name, ".botCycles"}, botCyc, expBot);
        checkOutput({name, ".busyCycles"}, busyCyc, expBusy);
        checkOutput({name, ".endCount"}, count, 0);
        tick();
        checkOutput({name, ".donePulse"}, done, 0);
    endtask

    initial begin
        int doneSeen;
        int found;
        int n;

        #1 rst = 1'b0;
        #1;
        checkOutput("rst.cntEn", cntEn, 0);
        checkOutput("rst.cntType", cntType, 0);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.phase", phase, 0);
        tick();
        tick();
        rst = 1'b1;
        loadCount(5'd0);

        $display("[TB] single sweep, cycles=1 dwell=0");
        applyStimulus(1'b1, 1'b0, 4'd1, 4'd0);
        runSweep("single", 200, 65, 31, 31, 0, 0, 64);

        $display("[TB] two periods, dwell=3");
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd3);
        runSweep("dwell", 300, 138, 62, 62, 6, 3, 137);

        $display("[TB] continuous mode then stop mid-UP");
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
        doneSeen = 0;
        for (int k = 1; k <= 1200; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (done) doneSeen++;
        end
        checkOutput("cont.noDone", doneSeen, 0);
        checkOutput("cont.busy", busy, 1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (phase == ST_UP && count == 5'd10) begin
                found = 1;
                break;
            end
            tick();
        end
        checkOutput("cont.reachUp10", found, 1);
        stop = 1'b1;
        #1;
        checkOutput("stop.cntEnSameCycle", cntEn, 0);
        tick();
        stop = 1'b0;
        checkOutput("stop.phase", phase, 0);
        checkOutput("stop.busy", busy, 0);
        checkOutput("stop.noDone", done, 0);
        checkOutput("stop.countHeld", count, 10);

        $display("[TB] start and stop together in IDLE");
        applyStimulus(1'b1, 1'b1, 4'd1, 4'd0);
        tick();
        checkOutput("startStop.phase", phase, 0);
        checkOutput("startStop.busy", busy, 0);
        applyStimulus(1'b0, 1'b0, 4'd1, 4'd0);

        $display("[TB] start with counter at 31, start pulsed while busy");
        loadCount(5'd31);
        checkOutput("top31.loaded", count, 31);
        applyStimulus(1'b1, 1'b0, 4'd1, 4'd0);
        tick();
        start = 1'b0;
        checkOutput("top31.phaseUp", phase, 1);
        checkOutput("top31.enLow", cntEn, 0);
        tick();
        checkOutput("top31.phaseDown", phase, 3);
        checkOutput("top31.enDown", cntEn, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busyStart.phase", phase, 3);
        checkOutput("busyStart.count", count, 30);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        checkOutput("top31.edgesToDone", n, 31);
        tick();

        $display("[TB] reset mid-DOWN at 17, then fresh start");
        applyStimulus(1'b1, 1'b0, 4'd3, 4'd2);
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (phase == ST_DOWN && count == 5'd17) begin
                found = 1;
                break;
            end
            tick();
        end
        checkOutput("midRst.reachDown17", found, 1);
        rst = 1'b0;
        #1;
        checkOutput("midRst.cntEn", cntEn, 0);
        checkOutput("midRst.cntType", cntType, 0);
        checkOutput("midRst.busy", busy, 0);
        checkOutput("midRst.done", done, 0);
        checkOutput("midRst.phase", phase, 0);
        tick();
        rst = 1'b1;
        checkOutput("midRst.countHeld", count, 17);
        applyStimulus(1'b1, 1'b0, 4'd1, 4'd1);
        runSweep("fresh", 200, 49, 14, 31, 1, 0, 48);

        checkOutput("noWrap", wrapErrs, 0);
        checkOutput("typeMatchesPhase", typeErrs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
